// File: rtl/router_fsm.sv
// router_fsm: 1x3 router control FSM sequencing header, payload and parity writes into the selected FIFO.
module router_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_rst_0,
    input  logic       soft_rst_1,
    input  logic       soft_rst_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY
    } state_t;

    state_t     r_state;
    logic [1:0] r_addr;
    logic [3:0] w_empty;
    logic [3:0] w_srst;
    logic       w_soft;

    // Slot 3 is padded with 0 so the invalid address never matches a FIFO
    assign w_empty = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign w_srst  = {1'b0, soft_rst_2, soft_rst_1, soft_rst_0};
    assign w_soft  = w_srst[r_addr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= DECODE_ADDRESS;
            r_addr  <= 2'd0;
        end else begin
            if (r_state == DECODE_ADDRESS && pkt_valid)
                r_addr <= data_in;
            if (w_soft)
                r_state <= DECODE_ADDRESS;
            else
                case (r_state)
                    DECODE_ADDRESS:
                        if (pkt_valid && data_in != 2'd3)
                            r_state <= w_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    LOAD_FIRST_DATA:    r_state <= LOAD_DATA;
                    LOAD_DATA:
                        r_state <= fifo_full ? FIFO_FULL_STATE : (!pkt_valid ? LOAD_PARITY : LOAD_DATA);
                    FIFO_FULL_STATE:    r_state <= fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
                    LOAD_AFTER_FULL:
                        r_state <= parity_done ? DECODE_ADDRESS : (low_pkt_valid ? LOAD_PARITY : LOAD_DATA);
                    LOAD_PARITY:        r_state <= CHECK_PARITY_ERROR;
                    CHECK_PARITY_ERROR: r_state <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                    WAIT_TILL_EMPTY:    r_state <= w_empty[r_addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    default:            r_state <= DECODE_ADDRESS;
                endcase
        end
    end

    assign detect_add    = r_state == DECODE_ADDRESS;
    assign lfd_state     = r_state == LOAD_FIRST_DATA;
    assign ld_state      = r_state == LOAD_DATA;
    assign laf_state     = r_state == LOAD_AFTER_FULL;
    assign full_state    = r_state == FIFO_FULL_STATE;
    assign rst_int_reg   = r_state == CHECK_PARITY_ERROR;
    assign write_enb_reg = r_state inside {LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY};
    assign busy          = r_state inside {LOAD_FIRST_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL,
                                           LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY};
endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: table-driven directed check of router_fsm state outputs.
module tb_router_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = 2'd0;
    logic       fifo_full = 1'b0;
    logic       fifo_empty_0 = 1'b0, fifo_empty_1 = 1'b0, fifo_empty_2 = 1'b0;
    logic       soft_rst_0 = 1'b0, soft_rst_1 = 1'b0, soft_rst_2 = 1'b0;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;

    router_fsm dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_rst_0(soft_rst_0), .soft_rst_1(soft_rst_1), .soft_rst_2(soft_rst_2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    // Output order: detect_add, lfd, ld, laf, full, write_enb, rst_int, busy
    localparam logic [7:0] E_DA  = 8'b1000_0000;
    localparam logic [7:0] E_LFD = 8'b0100_0001;
    localparam logic [7:0] E_LD  = 8'b0010_0100;
    localparam logic [7:0] E_FFS = 8'b0000_1001;
    localparam logic [7:0] E_LAF = 8'b0001_0101;
    localparam logic [7:0] E_LP  = 8'b0000_0101;
    localparam logic [7:0] E_CPE = 8'b0000_0011;
    localparam logic [7:0] E_WTE = 8'b0000_0001;

    typedef struct {
        logic       r;
        logic       pv;
        logic [1:0] din;
        logic       full;
        logic [2:0] emp;
        logic [2:0] srst;
        logic       pd;
        logic       lpv;
        logic [7:0] exp;
    } vec_t;

    vec_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic add(input logic r, input logic pv, input logic [1:0] d, input logic f,
                       input logic [2:0] e, input logic [2:0] s, input logic pd,
                       input logic lpv, input logic [7:0] x);
        q.push_back('{r, pv, d, f, e, s, pd, lpv, x});
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy};
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: outputs=%b expected=%b", name, act, exp);
    endtask

    initial begin
        // Reset held with random inputs
        for (int i = 0; i < 2; i++) begin
            rst = 1'b0;
            {pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2} = 7'($urandom);
            {soft_rst_0, soft_rst_1, soft_rst_2, parity_done, low_pkt_valid} = 5'($urandom);
            @(posedge clk); #1;
            check($sformatf("reset%0d", i), E_DA);
        end

        // args: rst pv din full emp{2,1,0} srst{2,1,0} pd lpv expected
        add(1, 0, 1, 0, 3'b111, 0, 0, 0, E_DA);
        add(1, 1, 1, 0, 3'b010, 0, 0, 0, E_LFD);
        add(1, 1, 0, 0, 3'b010, 0, 0, 0, E_LD);
        add(1, 1, 0, 0, 3'b010, 0, 0, 0, E_LD);
        add(1, 1, 0, 0, 3'b010, 0, 0, 0, E_LD);
        add(1, 0, 0, 0, 3'b010, 0, 0, 0, E_LP);
        add(1, 0, 0, 0, 3'b010, 0, 0, 0, E_CPE);
        add(1, 0, 0, 0, 3'b010, 0, 0, 0, E_DA);
        add(1, 1, 0, 0, 3'b001, 0, 0, 0, E_LFD);
        add(1, 1, 0, 0, 3'b001, 0, 0, 0, E_LD);
        add(1, 1, 0, 0, 3'b001, 0, 0, 0, E_LD);
        for (int i = 0; i < 4; i++) add(1, 1, 0, 1, 3'b001, 0, 0, 0, E_FFS);
        add(1, 1, 0, 0, 3'b001, 0, 0, 0, E_LAF);
        add(1, 1, 0, 0, 3'b001, 0, 0, 0, E_LD);
        add(1, 1, 0, 0, 3'b001, 3'b010, 0, 0, E_LD);
        add(1, 1, 0, 0, 3'b001, 3'b001, 0, 0, E_DA);
        add(1, 1, 2, 0, 3'b000, 0, 0, 0, E_WTE);
        for (int i = 0; i < 4; i++) add(1, 1, 2, 0, (i % 2 == 0) ? 3'b001 : 3'b000, 0, 0, 0, E_WTE);
        add(1, 1, 2, 0, 3'b100, 0, 0, 0, E_LFD);
        add(1, 1, 2, 0, 3'b100, 0, 0, 0, E_LD);
        add(1, 0, 2, 0, 3'b100, 0, 0, 0, E_LP);
        add(1, 0, 2, 1, 3'b100, 0, 0, 0, E_CPE);
        add(1, 0, 2, 1, 3'b100, 0, 0, 0, E_FFS);
        add(1, 0, 2, 0, 3'b100, 0, 0, 0, E_LAF);
        add(1, 0, 2, 0, 3'b100, 0, 1, 1, E_DA);
        add(1, 1, 0, 0, 3'b001, 0, 0, 0, E_LFD);
        add(1, 1, 0, 0, 3'b001, 0, 0, 0, E_LD);
        add(1, 1, 0, 1, 3'b001, 0, 0, 0, E_FFS);
        add(1, 0, 0, 0, 3'b001, 0, 0, 1, E_LAF);
        add(1, 0, 0, 0, 3'b001, 0, 0, 1, E_LP);
        add(1, 0, 0, 0, 3'b001, 0, 0, 0, E_CPE);
        add(1, 0, 0, 0, 3'b001, 0, 0, 0, E_DA);
        for (int i = 0; i < 3; i++) add(1, 1, 3, 0, 3'b111, 3'b111, 0, 0, E_DA);
        add(1, 1, 1, 0, 3'b010, 0, 0, 0, E_LFD);
        add(1, 1, 1, 0, 3'b010, 0, 0, 0, E_LD);
        add(0, 1, 1, 0, 3'b010, 0, 0, 0, E_DA);

        foreach (q[i]) begin
            rst = q[i].r;
            pkt_valid = q[i].pv;
            data_in = q[i].din;
            fifo_full = q[i].full;
            {fifo_empty_2, fifo_empty_1, fifo_empty_0} = q[i].emp;
            {soft_rst_2, soft_rst_1, soft_rst_0} = q[i].srst;
            parity_done = q[i].pd;
            low_pkt_valid = q[i].lpv;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), q[i].exp);
        end

        // Soft reset of the selected FIFO overrides a pending LFD from WAIT_TILL_EMPTY
        rst = 1'b1; soft_rst_0 = 1'b0; soft_rst_1 = 1'b0; soft_rst_2 = 1'b0;
        pkt_valid = 1'b1; data_in = 2'd2; fifo_full = 1'b0;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = 3'b000;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        @(posedge clk); #1; check("wte_enter", E_WTE);
        fifo_empty_2 = 1'b1; soft_rst_2 = 1'b1;
        @(posedge clk); #1; check("wte_softrst", E_DA);
        soft_rst_2 = 1'b0; pkt_valid = 1'b0;
        @(posedge clk); #1; check("idle_after_softrst", E_DA);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
